act_argmax: RTL and testbench
=============================

ACT_ARGMAX -- requirements
Module: act_argmax

Interface
REQ-001 Parameter N_CLASS, default 10, number of fp16 activations collected per inference (2..64).
REQ-002 Parameter IDX_W, default $clog2(N_CLASS), width of class index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  pulse; begins a new collection.
REQ-006 in_valid  input  1  upstream sigmoid done (sticky level); accepted on its 0->1 edge only.
REQ-007 in_data  input  16  fp16 activation {sign, exp[4:0], man[9:0]}.
REQ-008 busy  output  1  high while collecting.
REQ-009 done  output  1  high (level) once N_CLASS values are processed.
REQ-010 max_idx  output  IDX_W  index of largest activation.
REQ-011 max_val  output  16  largest activation.
REQ-012 drop  output  1  sticky; an in_valid edge arrived outside COLLECT.
REQ-013 rd_addr  input  IDX_W  readback address; rd_data  output  16  stored activation (see Configuration).

Function
REQ-014 FSM states IDLE, COLLECT, DONE; reset state IDLE.
REQ-015 IDLE or DONE + start -> COLLECT: count=0, done=0, busy=1; max_idx/max_val unchanged until first accept.
REQ-016 start while in COLLECT is ignored.
REQ-017 Accept = in_valid high this cycle and low the previous cycle (registered edge detect); prev-valid register resets to 0.
REQ-018 On accept with count==0: max_val<=in_data, max_idx<=0 unconditionally.
REQ-019 On accept with count>0: replace max only if in_data strictly greater than max_val; ties keep lower index.
REQ-020 fp16 ordering: +0 and -0 equal; positive > negative; both positive compare {exp,man} unsigned larger wins; both negative smaller {exp,man} wins; NaN/Inf treated as ordinary bit patterns.
REQ-021 count increments per accept; accept at count==N_CLASS-1 -> DONE next edge: busy=0, done=1, held until next start or reset.
REQ-022 Latency: done rises one cycle after the final accept edge is sampled.
REQ-023 Accept edge in IDLE or DONE: data discarded, drop<=1; drop cleared only by start or reset.
REQ-024 start and accept edge in the same cycle from IDLE/DONE: start wins, edge discarded, drop set.

Reset
REQ-025 Async reset: state=IDLE, count=0, busy=0, done=0, drop=0, max_idx=0, max_val=16'h0000, prev-valid=0, buffer cleared to 0.
REQ-026 Reset mid-COLLECT abandons collection; no partial done.

Configuration
REQ-027 Macro ACT_ARGMAX_READBACK_EN defined: N_CLASS x 16 buffer stores each accepted value at index count; rd_data = buffer[rd_addr] combinationally; rd_addr >= N_CLASS returns 0.
REQ-028 Macro undefined: no buffer instantiated, rd_data tied to 16'h0000, rd_addr unused; argmax behaviour identical.

Structure
REQ-029 Shared package dnn_pkg holds fp16_t typedef (16-bit packed), FP16_EXP_W=5, FP16_MAN_W=10, FP16_ZERO constant, FSM state enum.
REQ-030 Sub-module fp16_gt (combinational, a/b fp16 in, gt out) implements REQ-020; instantiated once.

Verification
REQ-031 N_CLASS=4, start, edges with 0x3800,0x3C00,0x3A00,0x3400 -> done=1 one cycle after 4th accept, max_idx=1, max_val=0x3C00.
REQ-032 Values 0xBC00,0x8000,0x0000,0xC000 -> max_idx=1 (-0 first, tie with +0 keeps lower), max_val=0x8000.
REQ-033 in_valid held high 5 cycles then low then high -> exactly 2 accepts counted.
REQ-034 in_valid edge before start -> drop=1, count stays 0; subsequent start clears drop.
REQ-035 Async reset asserted mid-COLLECT after 2 accepts -> outputs immediately at reset values, done never asserted.
REQ-036 With ACT_ARGMAX_READBACK_EN, after REQ-031 sequence rd_addr=2 -> rd_data=0x3A00; without macro rd_data=0x0000.

Source files
------------

// File: rtl/dnn_pkg.sv
// ---------------------------------------------------------------------------
// dnn_pkg
// Shared types and constants for the DNN output-stage blocks.
//   fp16_t          : packed half-precision word {sign, exp[4:0], man[9:0]}
//   FP16_EXP_W      : exponent field width
//   FP16_MAN_W      : mantissa field width
//   FP16_ZERO       : positive zero bit pattern
//   argmax_state_t  : collection FSM states
// ---------------------------------------------------------------------------
package dnn_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    typedef logic [FP16_EXP_W+FP16_MAN_W:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/act_argmax_fp16_gt.sv
// ---------------------------------------------------------------------------
// fp16_gt
// Combinational "a strictly greater than b" for fp16 bit patterns.
// Ports:
//   a, b : fp16 operands
//   gt   : 1 when a > b
// +0 and -0 compare equal. NaN and Inf are not special-cased; they order
// by sign and magnitude bits like any other pattern.
// ---------------------------------------------------------------------------
module fp16_gt
    import dnn_pkg::*;
(
    input  fp16_t a,
    input  fp16_t b,
    output logic  gt
);

    localparam int MAG_W = FP16_EXP_W + FP16_MAN_W;

    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic             neg_a;
    logic             neg_b;

    assign mag_a = a[MAG_W-1:0];
    assign mag_b = b[MAG_W-1:0];

    // A zero of either sign is folded onto +0 so both zeros compare equal.
    assign neg_a = a[MAG_W] & (mag_a != '0);
    assign neg_b = b[MAG_W] & (mag_b != '0);

    always_comb begin
        gt = 1'b0;
        if (neg_a != neg_b) begin
            gt = neg_b;
        end else if (!neg_a) begin
            gt = (mag_a > mag_b);
        end else begin
            // Both negative: the smaller magnitude is the larger value.
            gt = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/act_argmax.sv
// ---------------------------------------------------------------------------
// act_argmax
// Collects N_CLASS fp16 activations, one per rising edge of in_valid, and
// reports the index and value of the largest one.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : pulse, begins a new collection from IDLE or DONE
//   in_valid, in_data : sticky valid level and fp16 activation
//   busy, done        : collecting / result ready (level)
//   max_idx, max_val  : running argmax result
//   drop              : sticky, a valid edge arrived while not collecting
//   rd_addr, rd_data  : readback of stored activations
// Optional feature: define ACT_ARGMAX_READBACK_EN to build the readback
// buffer; otherwise rd_data is constant zero and rd_addr is ignored.
// ---------------------------------------------------------------------------
module act_argmax
    import dnn_pkg::*;
#(
    parameter int N_CLASS = 10,
    parameter int IDX_W   = $clog2(N_CLASS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] max_idx,
    output logic [15:0]      max_val,
    output logic             drop,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [15:0]      rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    argmax_state_t    state;
    argmax_state_t    next_state;
    logic [IDX_W-1:0] count;
    logic             prev_valid;
    logic             accept;
    logic             in_gt_max;
    logic             collecting;

    assign accept     = in_valid & ~prev_valid;
    assign collecting = (state == ST_COLLECT);
    assign busy       = collecting;
    assign done       = (state == ST_DONE);

    fp16_gt u_gt (
        .a  (in_data),
        .b  (max_val),
        .gt (in_gt_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) next_state = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (accept && (count == LAST_IDX)) next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The first accepted value seeds the maximum unconditionally, so a stale
    // result from the previous inference never competes with new data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid <= 1'b0;
            count      <= '0;
            drop       <= 1'b0;
            max_idx    <= '0;
            max_val    <= FP16_ZERO;
        end else begin
            prev_valid <= in_valid;
            if (collecting) begin
                if (accept) begin
                    count <= count + 1'b1;
                    if ((count == '0) || in_gt_max) begin
                        max_val <= in_data;
                        max_idx <= count;
                    end
                end
            end else begin
                if (start) count <= '0;
                // An edge coinciding with start is still discarded and flagged.
                if (accept) begin
                    drop <= 1'b1;
                end else if (start) begin
                    drop <= 1'b0;
                end
            end
        end
    end

`ifdef ACT_ARGMAX_READBACK_EN
    logic [15:0] buf_mem [N_CLASS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CLASS; i++) buf_mem[i] <= '0;
        end else if (collecting && accept) begin
            buf_mem[count] <= in_data;
        end
    end

    assign rd_data = (32'(rd_addr) < N_CLASS) ? buf_mem[rd_addr] : 16'h0000;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = 16'h0000;
`endif

endmodule

// File: tb/tb_act_argmax.sv
// ---------------------------------------------------------------------------
// tb_act_argmax
// Directed bench for act_argmax with N_CLASS=4. Expected values are worked
// out by hand from the fp16 ordering rules.
// ---------------------------------------------------------------------------
module tb_act_argmax;

    localparam int N_CLASS = 4;
    localparam int IDX_W   = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] max_idx;
    logic [15:0]      max_val;
    logic             drop;
    logic [IDX_W-1:0] rd_addr;
    logic [15:0]      rd_data;

    int test_count = 0;
    int fail_count = 0;

    act_argmax #(.N_CLASS(N_CLASS), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .max_idx  (max_idx),
        .max_val  (max_val),
        .drop     (drop),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Raise in_valid with data for 'hold' edges, then drop it for one edge.
    task automatic applyStimulus(input logic [15:0] value, input int hold);
        in_data  = value;
        in_valid = 1'b1;
        repeat (hold) tick();
        in_valid = 1'b0;
        tick();
    endtask

    logic [15:0] exp_rd;

    initial begin
`ifdef ACT_ARGMAX_READBACK_EN
        exp_rd = 16'h3A00;
`else
        exp_rd = 16'h0000;
`endif
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        rd_addr  = 2'd2;
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_drop", 32'(drop), 32'd0);
        checkOutput("reset_max_idx", 32'(max_idx), 32'd0);
        checkOutput("reset_max_val", 32'(max_val), 32'h0000);
        checkOutput("reset_rd_data", 32'(rd_data), 32'h0000);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Positive values, max in slot 1, done one cycle after last accept.
        pulseStart();
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_done_low", 32'(done), 32'd0);
        applyStimulus(16'h3800, 1);
        applyStimulus(16'h3C00, 1);
        applyStimulus(16'h3A00, 1);
        checkOutput("t1_pre_done", 32'(done), 32'd0);
        in_data  = 16'h3400;
        in_valid = 1'b1;
        tick();
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_busy_low", 32'(busy), 32'd0);
        in_valid = 1'b0;
        tick();
        checkOutput("t1_max_idx", 32'(max_idx), 32'd1);
        checkOutput("t1_max_val", 32'(max_val), 32'h3C00);
        checkOutput("t1_rd_data", 32'(rd_data), 32'(exp_rd));
        checkOutput("t1_drop", 32'(drop), 32'd0);

        // Negatives and signed zeros: -0 at index 1 ties +0 at index 2.
        pulseStart();
        applyStimulus(16'hBC00, 1);
        applyStimulus(16'h8000, 1);
        applyStimulus(16'h0000, 1);
        applyStimulus(16'hC000, 1);
        checkOutput("t2_done", 32'(done), 32'd1);
        checkOutput("t2_max_idx", 32'(max_idx), 32'd1);
        checkOutput("t2_max_val", 32'(max_val), 32'h8000);

        // A level held for several cycles counts once.
        pulseStart();
        applyStimulus(16'h3000, 5);
        applyStimulus(16'h3100, 1);
        checkOutput("t3_busy_after2", 32'(busy), 32'd1);
        checkOutput("t3_max_val", 32'(max_val), 32'h3100);
        applyStimulus(16'h2000, 1);
        checkOutput("t3_busy_after3", 32'(busy), 32'd1);
        applyStimulus(16'h2000, 1);
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_max_idx", 32'(max_idx), 32'd1);

        // start and valid edge together from DONE: start wins, edge dropped.
        in_data  = 16'h5000;
        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t4_drop", 32'(drop), 32'd1);
        checkOutput("t4_busy", 32'(busy), 32'd1);
        checkOutput("t4_max_kept", 32'(max_val), 32'h3100);
        in_valid = 1'b0;
        tick();
        applyStimulus(16'h1000, 1);
        checkOutput("t4_first_val", 32'(max_val), 32'h1000);
        checkOutput("t4_first_idx", 32'(max_idx), 32'd0);
        checkOutput("t4_drop_sticky", 32'(drop), 32'd1);

        // Edge in IDLE sets drop; start clears it; count starts at zero.
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(16'h7000, 1);
        checkOutput("t5_drop", 32'(drop), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        pulseStart();
        checkOutput("t5_drop_clr", 32'(drop), 32'd0);
        applyStimulus(16'h4000, 1);
        applyStimulus(16'h4400, 1);
        checkOutput("t5_max_idx", 32'(max_idx), 32'd1);
        checkOutput("t5_max_val", 32'(max_val), 32'h4400);

        // Asynchronous reset mid-collection clears everything at once.
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_max_val", 32'(max_val), 32'h0000);
        checkOutput("t6_max_idx", 32'(max_idx), 32'd0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checkOutput("t6_no_done", 32'(done), 32'd0);
        checkOutput("t6_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
